// File: rtl/key_arbiter_if.sv
// Key arbiter bus: raw key levels and flush in, grant pulse and status out.
interface key_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
);
  logic [N-1:0]  keys;
  logic          clear;
  logic [N-1:0]  out;
  logic [IW-1:0] out_idx;
  logic          valid;
  logic          strobe;
  logic [N-1:0]  pending;
  logic          busy;

  // master: front panel / environment; slave: the arbiter itself
  modport master (
    output keys, clear,
    input  out, out_idx, valid, strobe, pending, busy
  );

  modport slave (
    input  keys, clear,
    output out, out_idx, valid, strobe, pending, busy
  );
endinterface

// File: rtl/key_arbiter.sv
// Round-robin arbiter sharing one rate-limit holdoff window among N push buttons.
// Keys are synchronised, edge-detected, latched as pending and granted one at a time.
module key_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned DUR = 5_000_000 - 1,
  parameter int unsigned CW  = 23,
  parameter int unsigned IW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  key_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StHoldoff} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  s1_q, s2_q, h_q;
  logic [N-1:0]  press;
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  out_q, out_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win, cand;
  logic          win_found;
  logic [CW-1:0] cnt_q, cnt_d;

  // All-ones after reset so a key held through reset never looks like a fresh rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
      h_q  <= '1;
    end else begin
      s1_q <= bus.keys;
      s2_q <= s1_q;
      h_q  <= s2_q;
    end
  end

  assign press = s2_q & ~h_q;

  // First pending bit scanning from ptr_q upward with wrap.
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr_q) + k) % N);
      if (!win_found && pend_q[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (win_found && !bus.clear) begin
          out_d   = N'(1) << win;
          idx_d   = win;
          ptr_d   = (win == IW'(N - 1)) ? '0 : win + 1'b1;
          cnt_d   = CW'(DUR);
          state_d = StHoldoff;
        end
      end
      StHoldoff: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A press arriving in the grant cycle re-arms the bit; clear beats everything.
  always_comb begin
    pend_d = '0;
    if (!bus.clear) begin
      pend_d = (pend_q & ~out_d) | press;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_idx = idx_q;
  assign bus.valid   = |out_q;
  assign bus.strobe  = (state_q == StIdle) && !rst;
  assign bus.busy    = (state_q == StHoldoff);
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_key_arbiter.sv
// Bench for key_arbiter: per-cycle compare against a behavioural model plus
// directed scenarios with literal expectations on grant order and timing.
module tb_key_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned DUR = 9;
  localparam int unsigned CW  = 4;
  localparam int unsigned IW  = 2;

  logic clk;
  logic rst;

  key_arbiter_if #(.N(N), .IW(IW)) bus ();

  key_arbiter #(.N(N), .DUR(DUR), .CW(CW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: key sample history, pending set, rotating pointer,
  // and the number of clocks the holdoff window still has to run.
  logic [N-1:0] kh [0:2];
  logic [N-1:0] m_pend, m_out, m_press;
  int           m_idx, m_ptr, m_busy_left, m_w;
  bit           m_live = 1'b0;
  bit           m_found;

  int g_cyc[$];
  int g_idx[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 3; i++) kh[i] = '1;
      m_pend      = '0;
      m_out       = '0;
      m_idx       = 0;
      m_ptr       = 0;
      m_busy_left = 0;
      m_live      = 1'b1;
    end else begin
      m_press = kh[1] & ~kh[2];
      m_out   = '0;
      if (m_live) begin
        if (m_busy_left == 0 && m_pend != '0 && !bus.clear) begin
          m_found = 1'b0;
          m_w     = 0;
          for (int k = 0; k < int'(N); k++) begin
            if (!m_found && m_pend[(m_ptr + k) % N]) begin
              m_found = 1'b1;
              m_w     = (m_ptr + k) % N;
            end
          end
          m_out[m_w]  = 1'b1;
          m_idx       = m_w;
          m_ptr       = (m_w + 1) % N;
          m_busy_left = DUR + 1;
        end else if (m_busy_left > 0) begin
          m_busy_left--;
        end
        m_pend = bus.clear ? '0 : ((m_pend & ~m_out) | m_press);
      end
      kh[2] = kh[1];
      kh[1] = kh[0];
      kh[0] = bus.keys;
    end
    #1;
    if (m_live) begin
      chk("m_out",     32'(bus.out),     32'(m_out));
      chk("m_valid",   32'(bus.valid),   32'(m_out != '0));
      chk("m_idx",     32'(bus.out_idx), 32'(m_idx));
      chk("m_busy",    32'(bus.busy),    32'(m_busy_left > 0));
      chk("m_strobe",  32'(bus.strobe),  32'(m_busy_left == 0 && !rst));
      chk("m_pending", 32'(bus.pending), 32'(m_pend));
      if (bus.out != '0) begin
        g_cyc.push_back(cyc);
        g_idx.push_back(int'(bus.out_idx));
      end
    end
  end

  function automatic int gidx(input int k);
    return (k < g_idx.size()) ? g_idx[k] : -1;
  endfunction

  function automatic int ggap(input int k);
    return (k + 1 < g_cyc.size()) ? g_cyc[k + 1] - g_cyc[k] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base;

  initial begin
    rst       = 1'b1;
    bus.keys  = 4'b0010;
    bus.clear = 1'b0;

    // Key held through reset release must never become a request.
    tick(3);
    rst = 1'b0;
    tick(12);
    chk("hold_pend",   32'(bus.pending), 32'h0);
    chk("hold_out",    32'(bus.out),     32'h0);
    chk("hold_strobe", 32'(bus.strobe),  32'h1);
    chk("hold_grants", 32'(g_idx.size()), 32'h0);
    bus.keys = '0;
    tick(4);

    // Single press on key 2: pending +3, grant +4, 10 busy clocks.
    bus.keys = 4'b0100;
    tick(3);
    chk("t1_pend", 32'(bus.pending), 32'h4);
    chk("t1_out0", 32'(bus.out),     32'h0);
    bus.keys = '0;
    tick(1);
    chk("t1_out",   32'(bus.out),     32'h4);
    chk("t1_idx",   32'(bus.out_idx), 32'h2);
    chk("t1_valid", 32'(bus.valid),   32'h1);
    chk("t1_busy",  32'(bus.busy),    32'h1);
    tick(9);
    chk("t1_busy_last", 32'(bus.busy), 32'h1);
    tick(1);
    chk("t1_busy_end", 32'(bus.busy),   32'h0);
    chk("t1_strobe",   32'(bus.strobe), 32'h1);

    // Reset to bring the pointer back to 0, then keys 0,1,3 together.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    base = g_idx.size();
    bus.keys = 4'b1011;
    tick(3);
    bus.keys = '0;
    tick(40);
    chk("t2_count", 32'(g_idx.size() - base), 32'd3);
    chk("t2_g0",    32'(gidx(base)),          32'd0);
    chk("t2_g1",    32'(gidx(base + 1)),      32'd1);
    chk("t2_g2",    32'(gidx(base + 2)),      32'd3);
    chk("t2_gap0",  32'(ggap(base)),          32'd11);
    chk("t2_gap1",  32'(ggap(base + 1)),      32'd11);

    // Pointer now 0: keys 3 and 1 together -> 1 before 3.
    base = g_idx.size();
    bus.keys = 4'b1010;
    tick(3);
    bus.keys = '0;
    tick(30);
    chk("t3_count", 32'(g_idx.size() - base), 32'd2);
    chk("t3_g0",    32'(gidx(base)),          32'd1);
    chk("t3_g1",    32'(gidx(base + 1)),      32'd3);
    chk("t3_gap",   32'(ggap(base)),          32'd11);

    // Key 2 re-pressed during its own holdoff -> second grant 11 clocks later.
    base = g_idx.size();
    bus.keys = 4'b0100;
    tick(3);
    bus.keys = '0;
    tick(3);
    bus.keys = 4'b0100;
    tick(3);
    chk("t4_pend", 32'(bus.pending), 32'h4);
    chk("t4_busy", 32'(bus.busy),    32'h1);
    bus.keys = '0;
    tick(20);
    chk("t4_count", 32'(g_idx.size() - base), 32'd2);
    chk("t4_g0",    32'(gidx(base)),          32'd2);
    chk("t4_g1",    32'(gidx(base + 1)),      32'd2);
    chk("t4_gap",   32'(ggap(base)),          32'd11);

    // Same, but clear mid-holdoff: no second grant, holdoff length unchanged.
    base = g_idx.size();
    bus.keys = 4'b0100;
    tick(3);
    bus.keys = '0;
    tick(3);
    bus.keys = 4'b0100;
    tick(3);
    chk("t4c_pend", 32'(bus.pending), 32'h4);
    bus.keys  = '0;
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    chk("t4c_flushed", 32'(bus.pending), 32'h0);
    chk("t4c_busy",    32'(bus.busy),    32'h1);
    tick(3);
    chk("t4c_busy_last", 32'(bus.busy), 32'h1);
    tick(1);
    chk("t4c_busy_end", 32'(bus.busy),   32'h0);
    chk("t4c_strobe",   32'(bus.strobe), 32'h1);
    tick(20);
    chk("t4c_count", 32'(g_idx.size() - base), 32'd1);
    chk("t4c_g0",    32'(gidx(base)),          32'd2);

    // Reset four clocks into a holdoff with key 3 pending.
    base = g_idx.size();
    bus.keys = 4'b0001;
    tick(3);
    bus.keys = '0;
    tick(1);
    chk("t5_out", 32'(bus.out), 32'h1);
    bus.keys = 4'b1000;
    tick(4);
    chk("t5_pend", 32'(bus.pending), 32'h8);
    chk("t5_busy", 32'(bus.busy),    32'h1);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_busy",   32'(bus.busy),    32'h0);
    chk("t5_rst_pend",   32'(bus.pending), 32'h0);
    chk("t5_rst_strobe", 32'(bus.strobe),  32'h0);
    rst      = 1'b0;
    bus.keys = '0;
    tick(20);
    chk("t5_count", 32'(g_idx.size() - base), 32'd1);
    bus.keys = 4'b0010;
    tick(3);
    chk("t5_fresh_pend", 32'(bus.pending), 32'h2);
    bus.keys = '0;
    tick(1);
    chk("t5_fresh_out", 32'(bus.out),     32'h2);
    chk("t5_fresh_idx", 32'(bus.out_idx), 32'h1);
    tick(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
